flatten_stream: RTL and testbench
=================================

// Module: flatten_stream
// PURPOSE
//  Streams a multi-channel feature map (CHANNELS x HEIGHT x WIDTH, N-bit signed) out one element per
//  handshake toward the dense layer. Generalised flatten stage: channel count, selectable output order,
//  valid/ready backpressure, last/index side-band. Sits between the final pool stage and the FC engine.
// PARAMETERS
//  WIDTH     4   feature-map columns per channel
//  HEIGHT    4   feature-map rows per channel
//  CHANNELS  2   channel count
//  N         16  element width, signed two's complement
//  TOTAL = WIDTH*HEIGHT*CHANNELS (localparam); IW = $clog2(TOTAL) (min 1)
// PORTS
//  clk               in   1            rising-edge clock
//  reset_n           in   1            asynchronous reset, active-low
//  start             in   1            request a flatten pass; sampled only while idle
//  order             in   1            0 = CHW (channel outermost), 1 = HWC (channel innermost); sampled with start
//  feature_map_flat  in   N*TOTAL      element (c,y,x) at bits [N*((c*HEIGHT+y)*WIDTH+x) +: N]
//  busy              out  1            pass in progress
//  out_data          out  N signed     current element
//  out_valid         out  1            out_data/out_last/out_index valid
//  out_ready         in   1            downstream accepts when high with out_valid
//  out_last          out  1            current element is the final one of the pass
//  out_index         out  IW           position of current element in output sequence (0..TOTAL-1)
//  done              out  1            one-cycle pulse after final element accepted
// BEHAVIOUR
//  - Reset (reset_n low, async): state IDLE; busy, out_valid, out_last, done = 0; out_data, out_index = 0;
//    snapshot register and counters cleared. Reset mid-pass aborts; no done pulse.
//  - States: IDLE, STREAM. Clock and reset ports only; no other state.
//  - IDLE: on edge with start=1, capture feature_map_flat into snapshot reg and order into order_q;
//    x/y/c counters = 0; -> STREAM. Input may change afterwards without effect.
//  - Latency: out_valid high the cycle after start is sampled, presenting element 0 (c=y=x=0).
//  - STREAM: out_valid=1, busy=1. Handshake = out_valid & out_ready. No handshake -> all outputs hold
//    stable (out_ready may toggle freely; out_valid never drops mid-pass).
//  - On handshake: out_index+1; nested counters advance. CHW: x fastest, then y, then c.
//    HWC: c fastest, then x, then y. Counters wrap to 0 at WIDTH-1/HEIGHT-1/CHANNELS-1.
//  - out_data selected from snapshot via counters (no multiplier on index path beyond constants).
//  - out_last = 1 exactly when out_index == TOTAL-1.
//  - Handshake with out_last: next cycle -> IDLE, out_valid=0, out_last=0, busy=0, done=1 for one cycle.
//  - start while STREAM ignored (no restart, no snapshot update). start during done cycle accepted:
//    next pass begins, out_valid high the following cycle.
//  - CHANNELS=1 or WIDTH=HEIGHT=1 must work; both orders identical when CHANNELS=1.
// CONFIGURATION
//  FLATTEN_RELU_EN defined: out_data = 0 when selected element is negative, else element (fused ReLU).
//  Undefined: out_data = selected element unchanged (negative values pass through).
// TESTING  (W=2,H=2,C=2,N=8; element at flat position k holds k+1 unless stated)
//  1 CHW: start, order=0, out_ready=1 -> out_data 1..8 on consecutive cycles, out_last on 8, done next cycle.
//  2 HWC: start, order=1, out_ready=1 -> out_data 1,5,2,6,3,7,4,8; out_index 0..7; done after 8.
//  3 Backpressure: out_ready low 3 cycles at index 2 -> out_data=3, out_index=2 held; sequence unchanged.
//  4 Start ignored: pulse start with new map at index 4 -> stream finishes with original data, one done.
//  5 Reset mid-pass: reset_n low at index 3 -> all outputs 0 immediately; new start streams from index 0.
//  6 ReLU: position 1 = -3 (0xFD); with FLATTEN_RELU_EN -> out_data 0 at index 1; without -> 0xFD.

Source files
------------

// File: rtl/flatten_stream_if.sv
// Output stream of the flatten stage: one signed element per valid/ready handshake,
// with last/index side-band.
interface flatten_stream_if #(
    parameter int unsigned N  = 16,
    parameter int unsigned IW = 5
);
    logic signed [N-1:0]  out_data;
    logic                 out_valid;
    logic                 out_ready;
    logic                 out_last;
    logic [IW-1:0]        out_index;

    modport master (
        output out_data, out_valid, out_last, out_index,
        input  out_ready
    );

    modport slave (
        input  out_data, out_valid, out_last, out_index,
        output out_ready
    );
endinterface

// File: rtl/flatten_stream.sv
// Streams a CHANNELS x HEIGHT x WIDTH feature map out one element per handshake, in CHW or HWC order.
// Optional fused ReLU on the output path when FLATTEN_RELU_EN is defined.
module flatten_stream #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned HEIGHT   = 4,
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned N        = 16
) (
    input  logic                                   clk,
    input  logic                                   reset_n,
    input  logic                                   start,
    input  logic                                   order,
    input  logic [N*WIDTH*HEIGHT*CHANNELS-1:0]     feature_map_flat,
    output logic                                   busy,
    output logic                                   done,
    flatten_stream_if.master                       bus
);
    localparam int unsigned TOTAL = WIDTH * HEIGHT * CHANNELS;
    localparam int unsigned IW    = (TOTAL > 1)    ? $clog2(TOTAL)    : 1;
    localparam int unsigned XW    = (WIDTH > 1)    ? $clog2(WIDTH)    : 1;
    localparam int unsigned YW    = (HEIGHT > 1)   ? $clog2(HEIGHT)   : 1;
    localparam int unsigned CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_STREAM = 1'b1;

    logic [0:0]         state_q, state_d;
    logic [N*TOTAL-1:0] snap_q, snap_d;
    logic               order_q, order_d;
    logic [XW-1:0]      x_q, x_d, x_n;
    logic [YW-1:0]      y_q, y_d, y_n;
    logic [CW-1:0]      c_q, c_d, c_n;
    logic [IW-1:0]      idx_q, idx_d, idx_n;
    logic [N-1:0]       data_q, data_d;
    logic               valid_q, valid_d;
    logic               last_q, last_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               hs;

    logic [N-1:0] elem [CHANNELS][HEIGHT][WIDTH];

    // Constant-offset view of the snapshot so selection is a pure mux on the counters
    for (genvar gc = 0; gc < int'(CHANNELS); gc++) begin : g_c
        for (genvar gy = 0; gy < int'(HEIGHT); gy++) begin : g_y
            for (genvar gx = 0; gx < int'(WIDTH); gx++) begin : g_x
                assign elem[gc][gy][gx] = snap_q[N*((gc*HEIGHT+gy)*WIDTH+gx) +: N];
            end
        end
    end

    function automatic logic [N-1:0] relu(input logic [N-1:0] v);
`ifdef FLATTEN_RELU_EN
        return v[N-1] ? '0 : v;
`else
        return v;
`endif
    endfunction

    assign hs    = valid_q & bus.out_ready;
    assign idx_n = idx_q + IW'(1);

    // Next position of the nested counters for the captured order
    always_comb begin
        x_n = x_q;
        y_n = y_q;
        c_n = c_q;
        if (!order_q) begin
            if (x_q == XW'(WIDTH-1)) begin
                x_n = '0;
                if (y_q == YW'(HEIGHT-1)) begin
                    y_n = '0;
                    c_n = (c_q == CW'(CHANNELS-1)) ? '0 : c_q + CW'(1);
                end else begin
                    y_n = y_q + YW'(1);
                end
            end else begin
                x_n = x_q + XW'(1);
            end
        end else begin
            if (c_q == CW'(CHANNELS-1)) begin
                c_n = '0;
                if (x_q == XW'(WIDTH-1)) begin
                    x_n = '0;
                    y_n = (y_q == YW'(HEIGHT-1)) ? '0 : y_q + YW'(1);
                end else begin
                    x_n = x_q + XW'(1);
                end
            end else begin
                c_n = c_q + CW'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        snap_d  = snap_q;
        order_d = order_q;
        x_d     = x_q;
        y_d     = y_q;
        c_d     = c_q;
        idx_d   = idx_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    snap_d  = feature_map_flat;
                    order_d = order;
                    x_d     = '0;
                    y_d     = '0;
                    c_d     = '0;
                    idx_d   = '0;
                    data_d  = relu(feature_map_flat[N-1:0]);
                    valid_d = 1'b1;
                    last_d  = (TOTAL == 1);
                    busy_d  = 1'b1;
                end
            end
            S_STREAM: begin
                if (hs) begin
                    if (last_q) begin
                        state_d = S_IDLE;
                        x_d     = '0;
                        y_d     = '0;
                        c_d     = '0;
                        idx_d   = '0;
                        data_d  = '0;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        x_d    = x_n;
                        y_d    = y_n;
                        c_d    = c_n;
                        idx_d  = idx_n;
                        data_d = relu(elem[c_n][y_n][x_n]);
                        last_d = (idx_n == IW'(TOTAL-1));
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            snap_q  <= '0;
            order_q <= 1'b0;
            x_q     <= '0;
            y_q     <= '0;
            c_q     <= '0;
            idx_q   <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            snap_q  <= snap_d;
            order_q <= order_d;
            x_q     <= x_d;
            y_q     <= y_d;
            c_q     <= c_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign bus.out_data  = data_q;
    assign bus.out_valid = valid_q;
    assign bus.out_last  = last_q;
    assign bus.out_index = idx_q;
endmodule

// File: tb/tb_flatten_stream.sv
// Directed bench for flatten_stream at W=2,H=2,C=2,N=8: orders, backpressure, ignored start,
// mid-pass reset and the ReLU path.
module tb_flatten_stream;
    localparam int unsigned NB  = 8;
    localparam int unsigned IWB = 3;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic        order;
    logic [63:0] fm;
    logic        busy;
    logic        done;
    logic [7:0]  data_u;
    logic [7:0]  hwc [8] = '{8'd1, 8'd5, 8'd2, 8'd6, 8'd3, 8'd7, 8'd4, 8'd8};
    logic [7:0]  exp_relu;
    int          total = 0;
    int          bad   = 0;

    flatten_stream_if #(.N(NB), .IW(IWB)) ifc ();

    flatten_stream #(
        .WIDTH(2), .HEIGHT(2), .CHANNELS(2), .N(NB)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .start            (start),
        .order            (order),
        .feature_map_flat (fm),
        .busy             (busy),
        .done             (done),
        .bus              (ifc.master)
    );

    assign data_u = ifc.out_data;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_elem(input string tag, input logic [7:0] d, input int idx, input logic last);
        chk({tag, ".valid"}, 32'(ifc.out_valid), 32'd1);
        chk({tag, ".data"},  32'(data_u), 32'(d));
        chk({tag, ".index"}, 32'(ifc.out_index), 32'(idx));
        chk({tag, ".last"},  32'(ifc.out_last), 32'(last));
    endtask

    task automatic chk_idle_zero(input string tag);
        chk({tag, ".busy"},  32'(busy), 32'd0);
        chk({tag, ".done"},  32'(done), 32'd0);
        chk({tag, ".valid"}, 32'(ifc.out_valid), 32'd0);
        chk({tag, ".last"},  32'(ifc.out_last), 32'd0);
        chk({tag, ".data"},  32'(data_u), 32'd0);
        chk({tag, ".index"}, 32'(ifc.out_index), 32'd0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_seq();
        for (int k = 0; k < 8; k++) fm[8*k +: 8] = 8'(k + 1);
    endtask

    initial begin
        reset_n       = 1'b0;
        start         = 1'b0;
        order         = 1'b0;
        ifc.out_ready = 1'b0;
        set_seq();
        #12;
        chk_idle_zero("reset");
        reset_n = 1'b1;

        // CHW pass, ready always high
        ifc.out_ready = 1'b1;
        start = 1'b1; order = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_elem("chw", 8'(k + 1), k, k == 7);
            chk("chw.busy", 32'(busy), 32'd1);
            step();
        end
        chk("chw.done",  32'(done), 32'd1);
        chk("chw.valid", 32'(ifc.out_valid), 32'd0);
        chk("chw.busy0", 32'(busy), 32'd0);
        chk("chw.last0", 32'(ifc.out_last), 32'd0);

        // HWC pass started during the done cycle
        start = 1'b1; order = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_elem("hwc", hwc[k], k, k == 7);
            step();
        end
        chk("hwc.done", 32'(done), 32'd1);
        step();
        chk("hwc.done_pulse", 32'(done), 32'd0);
        chk("hwc.valid0",     32'(ifc.out_valid), 32'd0);

        // Backpressure at index 2
        start = 1'b1; order = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_elem("bp", 8'(k + 1), k, k == 7);
            if (k == 2) begin
                ifc.out_ready = 1'b0;
                repeat (3) begin
                    step();
                    chk_elem("bp_hold", 8'd3, 2, 1'b0);
                end
                ifc.out_ready = 1'b1;
            end
            step();
        end
        chk("bp.done", 32'(done), 32'd1);
        step();

        // Start with a new map mid-pass is ignored
        start = 1'b1; order = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_elem("ign", 8'(k + 1), k, k == 7);
            if (k == 4) begin
                start = 1'b1; order = 1'b1; fm = {8{8'h55}};
            end
            step();
            start = 1'b0;
        end
        chk("ign.done", 32'(done), 32'd1);
        step();
        chk("ign.done_once", 32'(done), 32'd0);
        chk("ign.valid0",    32'(ifc.out_valid), 32'd0);
        chk("ign.busy0",     32'(busy), 32'd0);

        // Reset mid-pass at index 3
        set_seq();
        start = 1'b1; order = 1'b0;
        step();
        start = 1'b0;
        repeat (3) step();
        chk_elem("rst_pre", 8'd4, 3, 1'b0);
        reset_n = 1'b0;
        #1;
        chk_idle_zero("rst_async");
        step();
        chk_idle_zero("rst_held");
        reset_n = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_elem("rst_post", 8'(k + 1), k, k == 7);
            step();
        end
        chk("rst_post.done", 32'(done), 32'd1);
        step();

        // Negative element at position 1
`ifdef FLATTEN_RELU_EN
        exp_relu = 8'h00;
`else
        exp_relu = 8'hFD;
`endif
        fm[15:8] = 8'hFD;
        start = 1'b1; order = 1'b0;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
            chk_elem("relu", (k == 1) ? exp_relu : 8'(k + 1), k, k == 7);
            step();
        end
        chk("relu.done", 32'(done), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
